// File: rtl/feature_pkg.sv
// Shared types for the digit feature bitmap: grid geometry, controller states, bitmap word.
// Used by feature_bitmap_ctrl and the digit matcher.
package feature_pkg;

  localparam int unsigned BITMAP_DEPTH  = 32;
  localparam int unsigned BITMAP_ADDR_W = 5;
  localparam int unsigned BITMAP_CNT_W  = BITMAP_ADDR_W + 1;
  localparam int unsigned HIT_W         = BITMAP_ADDR_W + 1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CLEAR   = 3'd1,
    CAPTURE = 3'd2,
    SCAN    = 3'd3,
    DONE    = 3'd4
  } bm_state_t;

  typedef logic [BITMAP_DEPTH-1:0] bitmap_t;

endpackage

// File: rtl/feature_bitmap_ctrl.sv
// Controller for the 32x1 dual-port feature bitmap RAM: clear sweep, cell-hit sets, bitmap readout.
// Optional popcount output hit_count when FEATURE_BITMAP_POPCOUNT_EN is defined.
module feature_bitmap_ctrl
  import feature_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     frame_start,
  input  logic                     set_valid,
  input  logic [BITMAP_ADDR_W-1:0] set_idx,
  output logic                     set_ready,
  input  logic                     scan_start,
  output bitmap_t                  bitmap,
  output logic                     bitmap_valid,
  output logic                     busy,
  output logic [BITMAP_ADDR_W-1:0] ram_ada,
  output logic                     ram_dina,
  output logic                     ram_wrea,
  output logic                     ram_cea,
  output logic [BITMAP_ADDR_W-1:0] ram_adb,
  output logic                     ram_ceb,
  input  logic                     ram_doutb,
  output logic                     ram_reset,
  output logic                     ram_oce
`ifdef FEATURE_BITMAP_POPCOUNT_EN
  ,
  output logic [HIT_W-1:0]         hit_count
`endif
);

  localparam int unsigned DEPTH  = BITMAP_DEPTH;
  localparam int unsigned ADDR_W = BITMAP_ADDR_W;
  localparam int unsigned CNT_W  = BITMAP_CNT_W;

  bm_state_t          state;
  logic [CNT_W-1:0]   counter;
  logic [ADDR_W-1:0]  cap_idx;

  assign ram_reset = reset;
  assign ram_oce   = 1'b1;

  // Bit returned this cycle belongs to the address sampled one edge earlier.
  assign cap_idx = ADDR_W'(counter - CNT_W'(1));

  // Control FSM with registered handshake/status outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      counter      <= '0;
      bitmap       <= '0;
      bitmap_valid <= 1'b0;
      set_ready    <= 1'b0;
      busy         <= 1'b0;
`ifdef FEATURE_BITMAP_POPCOUNT_EN
      hit_count    <= '0;
`endif
    end else begin
      bitmap_valid <= 1'b0;
      if (frame_start) begin
        state     <= CLEAR;
        counter   <= '0;
        set_ready <= 1'b0;
        busy      <= 1'b1;
      end else begin
        case (state)
          IDLE: ;
          CLEAR: begin
            if (counter == CNT_W'(DEPTH - 1)) begin
              state     <= CAPTURE;
              counter   <= '0;
              set_ready <= 1'b1;
              busy      <= 1'b0;
            end else begin
              counter <= counter + CNT_W'(1);
            end
          end
          CAPTURE, DONE: begin
            if (scan_start) begin
              state     <= SCAN;
              counter   <= '0;
              set_ready <= 1'b0;
              busy      <= 1'b1;
`ifdef FEATURE_BITMAP_POPCOUNT_EN
              hit_count <= '0;
`endif
            end
          end
          SCAN: begin
            counter <= counter + CNT_W'(1);
            if (counter != '0) begin
              bitmap[cap_idx] <= ram_doutb;
`ifdef FEATURE_BITMAP_POPCOUNT_EN
              if (ram_doutb) hit_count <= hit_count + HIT_W'(1);
`endif
            end
            // Tail cycle: last bit lands, readout complete
            if (counter == CNT_W'(DEPTH)) begin
              state        <= DONE;
              counter      <= '0;
              bitmap_valid <= 1'b1;
              busy         <= 1'b0;
            end
          end
          default: begin
            state     <= IDLE;
            counter   <= '0;
            set_ready <= 1'b0;
            busy      <= 1'b0;
          end
        endcase
      end
    end
  end

  // RAM port drive; CAPTURE writes follow set_valid in the same cycle so the hit lands at that edge
  always_comb begin
    ram_ada  = '0;
    ram_dina = 1'b0;
    ram_wrea = 1'b0;
    ram_cea  = 1'b0;
    ram_adb  = '0;
    ram_ceb  = 1'b0;
    case (state)
      CLEAR: begin
        ram_cea  = 1'b1;
        ram_wrea = 1'b1;
        ram_ada  = counter[ADDR_W-1:0];
      end
      CAPTURE: begin
        if (set_valid) begin
          ram_cea  = 1'b1;
          ram_wrea = 1'b1;
          ram_dina = 1'b1;
          ram_ada  = set_idx;
        end
      end
      SCAN: begin
        ram_ceb = 1'b1;
        ram_adb = counter[ADDR_W-1:0];
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_feature_bitmap_ctrl.sv
// Bench for feature_bitmap_ctrl: behavioural 32x1 RAM, scoreboard of expected RAM writes and bitmap results.
module tb_feature_bitmap_ctrl;
  import feature_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        frame_start, set_valid, scan_start;
  logic [4:0]  set_idx;
  logic        set_ready, bitmap_valid, busy;
  bitmap_t     bitmap;
  logic [4:0]  ram_ada, ram_adb;
  logic        ram_dina, ram_wrea, ram_cea, ram_ceb, ram_doutb, ram_reset, ram_oce;
`ifdef FEATURE_BITMAP_POPCOUNT_EN
  logic [5:0]  hit_count;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        is_bitmap;
    logic [4:0]  addr;
    logic        data;
    logic [31:0] bmp;
    logic [5:0]  hits;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  feature_bitmap_ctrl dut (
    .clk(clk), .reset(reset), .frame_start(frame_start),
    .set_valid(set_valid), .set_idx(set_idx), .set_ready(set_ready),
    .scan_start(scan_start), .bitmap(bitmap), .bitmap_valid(bitmap_valid), .busy(busy),
    .ram_ada(ram_ada), .ram_dina(ram_dina), .ram_wrea(ram_wrea), .ram_cea(ram_cea),
    .ram_adb(ram_adb), .ram_ceb(ram_ceb), .ram_doutb(ram_doutb),
    .ram_reset(ram_reset), .ram_oce(ram_oce)
`ifdef FEATURE_BITMAP_POPCOUNT_EN
    , .hit_count(hit_count)
`endif
  );

  // Bypass-mode 32x1 RAM
  logic mem [0:31];
  always @(posedge clk) begin
    if (ram_cea && ram_wrea) mem[ram_ada] <= ram_dina;
    if (ram_reset) ram_doutb <= 1'b0;
    else if (ram_ceb) ram_doutb <= mem[ram_adb];
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_write(input logic [4:0] a, input logic d);
    exp_t e;
    e.is_bitmap = 1'b0; e.addr = a; e.data = d; e.bmp = '0; e.hits = '0;
    exp_q.push_back(e);
  endtask

  task automatic push_clear();
    for (int i = 0; i < 32; i++) push_write(5'(i), 1'b0);
  endtask

  task automatic push_bitmap(input logic [31:0] b, input logic [5:0] h);
    exp_t e;
    e.is_bitmap = 1'b1; e.addr = '0; e.data = 1'b0; e.bmp = b; e.hits = h;
    exp_q.push_back(e);
  endtask

  task automatic do_set(input logic [4:0] idx);
    set_valid = 1'b1; set_idx = idx;
    push_write(idx, 1'b1);
    tick();
    set_valid = 1'b0;
  endtask

  // Returns edges from scan acceptance to bitmap_valid, or -1 on timeout
  task automatic wait_valid(output int n);
    n = 0;
    while (!bitmap_valid && n < 40) begin
      tick();
      n++;
    end
    if (!bitmap_valid) begin
      n = -1;
      checks++; errors++;
      $display("FAIL wait_bitmap_valid: timeout after 40 cycles");
    end
  endtask

  // Scoreboard monitor: every RAM write and every bitmap_valid pulse must match the next expectation
  always @(negedge clk) begin
    exp_t e;
    if (ram_cea && ram_wrea) begin
      if (exp_q.size() == 0 || exp_q[0].is_bitmap) begin
        checks++; errors++;
        $display("FAIL unexpected_write: addr %0d data %0b", ram_ada, ram_dina);
      end else begin
        e = exp_q.pop_front();
        check("write_addr", 64'(ram_ada), 64'(e.addr));
        check("write_data", 64'(ram_dina), 64'(e.data));
      end
    end
    if (bitmap_valid) begin
      if (exp_q.size() == 0 || !exp_q[0].is_bitmap) begin
        checks++; errors++;
        $display("FAIL unexpected_bitmap_valid: bitmap %08h", bitmap);
      end else begin
        e = exp_q.pop_front();
        check("bitmap_value", 64'(bitmap), 64'(e.bmp));
`ifdef FEATURE_BITMAP_POPCOUNT_EN
        check("hit_count", 64'(hit_count), 64'(e.hits));
`endif
      end
    end
  end

  initial begin
    int n;
    reset = 1'b1; frame_start = 1'b0; set_valid = 1'b0; scan_start = 1'b0; set_idx = '0;
    repeat (3) tick();
    check("rst_bitmap", 64'(bitmap), 64'h0);
    check("rst_valid", 64'(bitmap_valid), 64'h0);
    check("rst_set_ready", 64'(set_ready), 64'h0);
    check("rst_busy", 64'(busy), 64'h0);
    check("rst_ram_en", 64'({ram_cea, ram_wrea, ram_ceb, ram_dina}), 64'h0);
    check("rst_ram_addr", 64'({ram_ada, ram_adb}), 64'h0);
    check("rst_ram_reset", 64'(ram_reset), 64'h1);
    check("ram_oce", 64'(ram_oce), 64'h1);
    reset = 1'b0;
    tick();

    // IDLE ignores sets and scan requests
    set_valid = 1'b1; set_idx = 5'd4; scan_start = 1'b1;
    tick();
    set_valid = 1'b0; scan_start = 1'b0;
    tick();
    check("idle_busy", 64'(busy), 64'h0);
    check("idle_set_ready", 64'(set_ready), 64'h0);

    // Full clear sweep
    frame_start = 1'b1;
    push_clear();
    tick();
    frame_start = 1'b0;
    for (int i = 0; i < 32; i++) begin
      if (i == 0 || i == 31) begin
        check("clear_busy", 64'(busy), 64'h1);
        check("clear_ada", 64'(ram_ada), 64'(i));
      end
      tick();
    end
    check("capture_set_ready", 64'(set_ready), 64'h1);
    check("capture_busy", 64'(busy), 64'h0);

    // Sets then scan with latency check
    do_set(5'd0); do_set(5'd5); do_set(5'd31); do_set(5'd5);
    scan_start = 1'b1;
    push_bitmap(32'h8000_0021, 6'd3);
    tick();
    scan_start = 1'b0;
    check("scan_set_ready", 64'(set_ready), 64'h0);
    wait_valid(n);
    check("scan_latency", 64'(n), 64'd33);
    tick();
    check("valid_one_cycle", 64'(bitmap_valid), 64'h0);

    // DONE: sets refused, rescan identical
    set_valid = 1'b1; set_idx = 5'd3;
    check("done_set_ready", 64'(set_ready), 64'h0);
    tick();
    set_valid = 1'b0;
    scan_start = 1'b1;
    push_bitmap(32'h8000_0021, 6'd3);
    tick();
    scan_start = 1'b0;
    wait_valid(n);
    check("rescan_latency", 64'(n), 64'd33);
    tick();

    // frame_start at clear address 10 restarts sweep; set requests held throughout
    frame_start = 1'b1;
    for (int i = 0; i <= 10; i++) push_write(5'(i), 1'b0);
    tick();
    frame_start = 1'b0;
    set_valid = 1'b1; set_idx = 5'd7;
    repeat (10) tick();
    check("clear_addr10", 64'(ram_ada), 64'd10);
    frame_start = 1'b1;
    push_clear();
    tick();
    frame_start = 1'b0;
    check("restart_ada", 64'(ram_ada), 64'd0);
    for (int i = 0; i < 32; i++) begin
      if (set_ready !== 1'b0) check("clear_no_set", 64'(set_ready), 64'h0);
      tick();
    end
    set_valid = 1'b0;
    check("restart_capture", 64'(set_ready), 64'h1);

    // Abort scan at counter 15: bits 0..13 refreshed, upper bits kept
    do_set(5'd1); do_set(5'd2);
    scan_start = 1'b1;
    tick();
    scan_start = 1'b0;
    repeat (15) tick();
    check("scan_adb15", 64'(ram_adb), 64'd15);
    frame_start = 1'b1;
    push_clear();
    tick();
    frame_start = 1'b0;
    check("abort_bitmap", 64'(bitmap), 64'h8000_0006);
    check("abort_valid", 64'(bitmap_valid), 64'h0);
    check("abort_clear_we", 64'({ram_cea, ram_wrea}), 64'h3);
    check("abort_clear_ada", 64'(ram_ada), 64'd0);
    repeat (32) tick();

    // Empty bitmap
    scan_start = 1'b1;
    push_bitmap(32'h0, 6'd0);
    tick();
    scan_start = 1'b0;
    wait_valid(n);
    tick();

    // Every cell set
    frame_start = 1'b1;
    push_clear();
    tick();
    frame_start = 1'b0;
    repeat (32) tick();
    for (int i = 0; i < 32; i++) do_set(5'(31 - i));
    scan_start = 1'b1;
    push_bitmap(32'hFFFF_FFFF, 6'd32);
    tick();
    scan_start = 1'b0;
    wait_valid(n);
    tick();

    // Reset mid-scan takes effect immediately
    scan_start = 1'b1;
    tick();
    scan_start = 1'b0;
    repeat (10) tick();
    reset = 1'b1;
    #1;
    check("midrst_bitmap", 64'(bitmap), 64'h0);
    check("midrst_status", 64'({bitmap_valid, busy, set_ready}), 64'h0);
    check("midrst_ram_en", 64'({ram_cea, ram_wrea, ram_ceb}), 64'h0);
    repeat (2) tick();
    reset = 1'b0;
    repeat (3) tick();
    check("post_rst_busy", 64'(busy), 64'h0);
    check("scoreboard_empty", 64'(exp_q.size()), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/feature_bitmap_ctrl.md
Name: feature_bitmap_ctrl

Overview:
- Controller for the 32x1 dual-port block RAM that holds the per-frame digit feature bitmap (one bit per grid cell).
- Port A: clear sweep at frame start, then single-bit "cell hit" set requests from the segment detector.
- Port B: sequential scan of all 32 bits into a 32-bit vector for the digit matcher.
- Sits between the segment detector, the matcher and the Gowin_DPB instance.

Parameters:
- DEPTH, 32, bitmap cells / RAM depth; fixed by the 32x1 RAM configuration.
- ADDR_W, 5, address width, equal to log2(DEPTH).

Ports:
- clk  in  1  system clock; also drives RAM clka/clkb.
- reset  in  1  asynchronous, active-high reset.
- frame_start  in  1  one-cycle pulse; begins a new frame.
- set_valid  in  1  cell-hit request.
- set_idx  in  5  cell index to set.
- set_ready  out  1  request accepted when set_valid && set_ready.
- scan_start  in  1  one-cycle pulse; request bitmap readout.
- bitmap  out  32  assembled bitmap; bit k = cell k.
- bitmap_valid  out  1  one-cycle pulse when bitmap is updated.
- busy  out  1  high in CLEAR and SCAN.
- ram_ada  out  5  RAM port A address.
- ram_dina  out  1  RAM port A write data.
- ram_wrea  out  1  RAM port A write enable.
- ram_cea  out  1  RAM port A clock enable.
- ram_adb  out  5  RAM port B address.
- ram_ceb  out  1  RAM port B clock enable.
- ram_doutb  in  1  RAM port B read data.
- ram_reset  out  1  equals reset; drives reseta/resetb.
- ram_oce  out  1  constant 1; drives ocea/oceb. Port B write enable is tied 0 at the top level.

Behaviour:
- RAM read model: bypass mode. Address is sampled at edge N; data is valid on ram_doutb after edge N and captured at edge N+1.
- States: IDLE, CLEAR, CAPTURE, SCAN, DONE.
- Reset values: state=IDLE, counter=0, bitmap=0, bitmap_valid=0, set_ready=0, busy=0. All RAM enables 0; addresses 0; dina 0.
- IDLE: RAM contents are undefined. Set requests and scan_start are ignored.
- frame_start has priority in every state. It moves to CLEAR with counter=0, aborts any scan, and suppresses bitmap_valid for that scan. A frame_start arriving during CLEAR restarts the sweep at 0.
- CLEAR: ram_cea=ram_wrea=1, ram_dina=0, ram_ada=counter.
  - Counter runs 0..31, one address per cycle; 32 write cycles total.
  - At the edge after address 31 is written, go to CAPTURE.
  - busy=1, set_ready=0.
- CAPTURE: set_ready=1.
  - While set_valid=1, the port A drive is combinational: ram_ada=set_idx, ram_dina=1, ram_wrea=ram_cea=1. The write lands at that edge.
  - Repeated sets to the same index are harmless.
  - scan_start goes to SCAN with counter=0. If set_valid and scan_start occur in the same cycle, the set is accepted and the scan starts next edge.
- SCAN: set_ready=0, busy=1, ram_ceb=1, ram_adb=counter.
  - Counter increments 0..31; a tail cycle captures the final bit.
  - Bit k is written into bitmap[k] at the edge after address k is sampled.
  - Bit 31 is captured at edge 33, counting the acceptance edge as edge 0. At that same edge bitmap_valid goes to 1 for one cycle and state goes to DONE.
  - bitmap bits not yet scanned keep their previous values.
- DONE: bitmap holds its value; set_ready=0. scan_start re-enters SCAN (rescan); frame_start goes to CLEAR.
- scan_start is ignored in IDLE, CLEAR and SCAN.
- Mid-operation reset returns to IDLE immediately. A partial clear leaves RAM undefined, so a frame_start is required before use.

Optional Feature:
- Macro: FEATURE_BITMAP_POPCOUNT_EN.
- Defined: adds output hit_count[5:0], reset 0.
  - Cleared on scan acceptance.
  - Incremented for each captured 1 bit during SCAN.
  - Final value is valid in the same cycle as bitmap_valid (range 0..32).
- Undefined: the port and counter do not exist; the rest of the behaviour is identical.

Decomposition:
- Shared package feature_pkg:
  - BITMAP_DEPTH=32 and BITMAP_ADDR_W=5.
  - State enum bm_state_t {IDLE, CLEAR, CAPTURE, SCAN, DONE}.
  - Bitmap type bitmap_t (32 bits), reused by the matcher.
- No sub-module. The FSM, the 6-bit sweep counter and the shift/capture register fit in one module. Gowin_DPB is instantiated by the parent.

Test Plan:
- Reset, then frame_start → exactly 32 cycles of ram_wrea=1 with ram_ada=0..31 and ram_dina=0 → set_ready=1 on the next cycle.
- CAPTURE: set indices 0, 5, 31, 5 → scan_start → bitmap_valid exactly 33 edges after acceptance with bitmap=32'h8000_0021. With macro: hit_count=3.
- frame_start at CLEAR address 10 → sweep restarts at 0; 32 further clear writes; no set accepted meanwhile.
- frame_start at SCAN counter 15 → no bitmap_valid; CLEAR begins next cycle; bitmap retains its old upper bits.
- DONE: set_valid=1, idx=3 → set_ready=0, no RAM write. Rescan returns the identical bitmap.
- Reset asserted mid-SCAN → same cycle: state IDLE, bitmap=0, bitmap_valid=0, busy=0, RAM enables 0.
